// File: rtl/snake_frame_render.sv
// Frame builder: reads snake segments from position memory, draws them plus the apple into a 36-cell LED frame, and flags head-on-apple / head-on-body.
// Latency: render_done on edge N+3 after render_start is sampled (edge 2 for N=0); render_start is ignored while busy. Optional SNAKE_RENDER_APPLE_BLINK_EN blinks the apple.
module snake_frame_render #(
    parameter int GRID_CELLS = 36,
    parameter int POS_W      = 6,
    parameter int ADDR_W     = 4
) (
    input  logic                  clock,
    input  logic                  restart_n,
    input  logic                  render_start,
    input  logic [ADDR_W-1:0]     snake_size,
    input  logic [POS_W-1:0]      apple_pos,
    input  logic                  apple_valid,
    output logic                  mem_rd_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [POS_W-1:0]      mem_data,
    output logic                  render_busy,
    output logic                  render_done,
    output logic [GRID_CELLS-1:0] leds,
    output logic                  apple_hit,
    output logic                  body_hit
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_READ,
        S_DRAIN,
        S_APPLE
    } state_t;

    localparam logic [POS_W-1:0]      CELL_LIM = POS_W'(GRID_CELLS);
    localparam logic [GRID_CELLS-1:0] ONE_HOT0 = GRID_CELLS'(1);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_W-1:0]       size_q;
    logic [GRID_CELLS-1:0]   shadow;
    logic                    data_pend;
    logic                    pend_head;
    logic [POS_W-1:0]        head_pos;
    logic                    head_ok;
    logic                    body_flag;
    logic                    data_in_grid;
    logic                    apple_draw;
    logic                    last_addr;
    logic [GRID_CELLS-1:0]   apple_mask;

    assign data_in_grid = (mem_data < CELL_LIM);
    assign last_addr    = (mem_addr == (size_q - 1'b1));
    assign apple_mask   = apple_draw ? (ONE_HOT0 << apple_pos) : '0;

`ifdef SNAKE_RENDER_APPLE_BLINK_EN
    logic parity;

    assign apple_draw = apple_valid && (apple_pos < CELL_LIM) && !parity;

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            parity <= 1'b0;
        end else if (state == S_APPLE) begin
            parity <= ~parity;
        end
    end
`else
    assign apple_draw = apple_valid && (apple_pos < CELL_LIM);
`endif

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (render_start) state_nxt = S_CLEAR;
            S_CLEAR: state_nxt = (size_q != '0) ? S_READ : S_APPLE;
            S_READ:  if (last_addr) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_APPLE;
            S_APPLE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge restart_n) begin
        if (!restart_n) begin
            size_q      <= '0;
            shadow      <= '0;
            data_pend   <= 1'b0;
            pend_head   <= 1'b0;
            head_pos    <= '0;
            head_ok     <= 1'b0;
            body_flag   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            render_busy <= 1'b0;
            render_done <= 1'b0;
            leds        <= '0;
            apple_hit   <= 1'b0;
            body_hit    <= 1'b0;
        end else begin
            render_done <= (state == S_APPLE);
            // Read data returns one cycle after the strobe; remember which beat is the head.
            data_pend   <= mem_rd_en;
            pend_head   <= mem_rd_en && (mem_addr == '0);

            if (data_pend) begin
                if (data_in_grid) begin
                    shadow <= shadow | (ONE_HOT0 << mem_data);
                end
                if (pend_head) begin
                    head_pos <= mem_data;
                    head_ok  <= data_in_grid;
                end else if (head_ok && (mem_data == head_pos)) begin
                    body_flag <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (render_start) begin
                        size_q      <= snake_size;
                        render_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    shadow    <= '0;
                    head_ok   <= 1'b0;
                    body_flag <= 1'b0;
                    if (size_q != '0) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                    end
                end
                S_READ: begin
                    if (last_addr) begin
                        mem_rd_en <= 1'b0;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                S_APPLE: begin
                    leds        <= shadow | apple_mask;
                    apple_hit   <= head_ok && apple_valid && (apple_pos == head_pos);
                    body_hit    <= body_flag;
                    render_busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_frame_render.sv
// Self-checking bench for snake_frame_render: directed plan cases plus randomized frames against a set-based frame model.
// Latency, single done pulse, leds/hit hold and abort-on-reset are all checked per frame.
module tb_snake_frame_render;

    logic        clock = 1'b0;
    logic        restart_n;
    logic        render_start;
    logic [3:0]  snake_size;
    logic [5:0]  apple_pos;
    logic        apple_valid;
    logic        mem_rd_en;
    logic [3:0]  mem_addr;
    logic [5:0]  mem_data = '0;
    logic        render_busy;
    logic        render_done;
    logic [35:0] leds;
    logic        apple_hit;
    logic        body_hit;

    logic [5:0]  mem [16];
    int          tests_run    = 0;
    int          tests_failed = 0;
    bit          parity       = 1'b0;

    int          fd, nd;
    logic [35:0] ol, el;
    logic        oa, ob;
    bit          gl, ea, eb;

    snake_frame_render dut (
        .clock        (clock),
        .restart_n    (restart_n),
        .render_start (render_start),
        .snake_size   (snake_size),
        .apple_pos    (apple_pos),
        .apple_valid  (apple_valid),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .render_busy  (render_busy),
        .render_done  (render_done),
        .leds         (leds),
        .apple_hit    (apple_hit),
        .body_hit     (body_hit)
    );

    always #5 clock = ~clock;

    // Synchronous position memory: data one cycle after the strobed address.
    always @(posedge clock) begin
        if (mem_rd_en) mem_data <= mem[mem_addr];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame = set of in-grid segment cells, plus apple when present (and visible this frame).
    function automatic void model_frame(input int n, input logic [5:0] ap, input bit av,
                                        input bit par, output logic [35:0] e_leds,
                                        output bit e_ah, output bit e_bh);
        bit show_apple;
        e_leds = '0;
        e_ah   = 1'b0;
        e_bh   = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (mem[i] < 36) e_leds[mem[i]] = 1'b1;
        end
        show_apple = av && (ap < 36);
`ifdef SNAKE_RENDER_APPLE_BLINK_EN
        if (par) show_apple = 1'b0;
`endif
        if (show_apple) e_leds[ap] = 1'b1;
        if (n > 0 && mem[0] < 36) begin
            e_ah = av && (ap == mem[0]);
            for (int i = 1; i < n; i++) begin
                if (mem[i] == mem[0]) e_bh = 1'b1;
            end
        end
    endfunction

    task automatic do_reset();
        restart_n    = 1'b0;
        render_start = 1'b0;
        snake_size   = '0;
        apple_pos    = '0;
        apple_valid  = 1'b0;
        repeat (3) @(negedge clock);
        restart_n = 1'b1;
        parity    = 1'b0;
    endtask

    // Starts a frame and watches 24 edges; start may be re-pulsed before edge extra_edge.
    task automatic run_frame(input int n, input int extra_edge, output int first_done,
                             output int n_done, output logic [35:0] o_leds,
                             output logic o_ah, output logic o_bh, output bit glitch);
        logic [35:0] pl;
        logic        pa, pb;
        @(negedge clock);
        snake_size   = n[3:0];
        render_start = 1'b1;
        pl = leds; pa = apple_hit; pb = body_hit;
        first_done = 0; n_done = 0; glitch = 1'b0;
        o_leds = 'x; o_ah = 1'bx; o_bh = 1'bx;
        @(posedge clock);
        @(negedge clock);
        for (int k = 1; k <= 24; k++) begin
            render_start = (k == extra_edge);
            @(posedge clock);
            #1;
            if (render_done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = k;
                    o_leds = leds; o_ah = apple_hit; o_bh = body_hit;
                end
            end else if (leds !== pl || apple_hit !== pa || body_hit !== pb) begin
                glitch = 1'b1;
            end
            pl = leds; pa = apple_hit; pb = body_hit;
            @(negedge clock);
        end
        render_start = 1'b0;
    endtask

    task automatic test_reset();
        restart_n = 1'b0;
        render_start = 1'b0;
        #3;
        tests_run++;
        if (leds !== 36'd0 || render_done !== 1'b0 || render_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: leds=%h done=%b busy=%b, want 0/0/0", leds, render_done, render_busy);
        end
        tests_run++;
        if (apple_hit !== 1'b0 || body_hit !== 1'b0 || mem_rd_en !== 1'b0 || mem_addr !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_mem_hits: ah=%b bh=%b rd=%b addr=%0d, want 0/0/0/0", apple_hit, body_hit, mem_rd_en, mem_addr);
        end
        do_reset();
    endtask

    task automatic test_basic();
        mem[0] = 6'd14; mem[1] = 6'd13; mem[2] = 6'd12;
        apple_pos = 6'd20; apple_valid = 1'b1;
        model_frame(3, apple_pos, apple_valid, parity, el, ea, eb);
        run_frame(3, -1, fd, nd, ol, oa, ob, gl);
        parity = ~parity;
        tests_run++;
        if (fd !== 6 || nd !== 1) begin
            tests_failed++;
            $display("FAIL basic_latency: done edge %0d count %0d, want edge 6 count 1", fd, nd);
        end
        tests_run++;
        if (ol !== ((36'd1 << 12) | (36'd1 << 13) | (36'd1 << 14) | (36'd1 << 20)) || ol !== el) begin
            tests_failed++;
            $display("FAIL basic_leds: got %h want %h", ol, el);
        end
        tests_run++;
        if (oa !== 1'b0 || ob !== 1'b0 || gl) begin
            tests_failed++;
            $display("FAIL basic_hits: ah=%b bh=%b glitch=%b, want 0 0 0", oa, ob, gl);
        end
    endtask

    task automatic test_empty_snake();
        apple_pos = 6'd35; apple_valid = 1'b1;
        model_frame(0, apple_pos, apple_valid, parity, el, ea, eb);
        run_frame(0, -1, fd, nd, ol, oa, ob, gl);
        parity = ~parity;
        tests_run++;
        if (fd !== 2 || nd !== 1) begin
            tests_failed++;
            $display("FAIL empty_latency: done edge %0d count %0d, want edge 2 count 1", fd, nd);
        end
        tests_run++;
        if (ol !== el || oa !== 1'b0 || ob !== 1'b0) begin
            tests_failed++;
            $display("FAIL empty_frame: leds=%h ah=%b bh=%b, want %h 0 0", ol, oa, ob, el);
        end
    endtask

    task automatic test_head_hits();
        mem[0] = 6'd7; mem[1] = 6'd8; mem[2] = 6'd14; mem[3] = 6'd7;
        apple_pos = 6'd7; apple_valid = 1'b1;
        model_frame(4, apple_pos, apple_valid, parity, el, ea, eb);
        run_frame(4, -1, fd, nd, ol, oa, ob, gl);
        parity = ~parity;
        tests_run++;
        if (fd !== 7 || ol !== ((36'd1 << 7) | (36'd1 << 8) | (36'd1 << 14))) begin
            tests_failed++;
            $display("FAIL hits_frame: edge %0d leds %h, want edge 7 leds bits 7,8,14", fd, ol);
        end
        tests_run++;
        if (oa !== 1'b1 || ob !== 1'b1) begin
            tests_failed++;
            $display("FAIL hits_flags: ah=%b bh=%b, want 1 1", oa, ob);
        end
    endtask

    task automatic test_busy_ignore();
        mem[0] = 6'd40; mem[1] = 6'd3;
        apple_pos = 6'd9; apple_valid = 1'b0;
        model_frame(2, apple_pos, apple_valid, parity, el, ea, eb);
        run_frame(2, 2, fd, nd, ol, oa, ob, gl);
        parity = ~parity;
        tests_run++;
        if (nd !== 1 || fd !== 5) begin
            tests_failed++;
            $display("FAIL busy_ignore: %0d done pulses first at edge %0d, want 1 at edge 5", nd, fd);
        end
        tests_run++;
        if (ol !== (36'd1 << 3) || oa !== 1'b0 || ob !== 1'b0 || gl) begin
            tests_failed++;
            $display("FAIL out_of_grid: leds=%h ah=%b bh=%b glitch=%b, want %h 0 0 0", ol, oa, ob, gl, el);
        end
    endtask

    task automatic test_back_to_back();
        int cnt;
        mem[0] = 6'd1; mem[1] = 6'd2;
        apple_pos = 6'd30; apple_valid = 1'b1;
        @(negedge clock);
        snake_size = 4'd2; render_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        render_start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        render_start = 1'b1;
        @(posedge clock);
        #1;
        parity = ~parity;
        tests_run++;
        if (render_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_done: done=%b at edge 5, want 1", render_done);
        end
        @(negedge clock);
        render_start = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            #1;
            if (render_busy || render_done) cnt++;
        end
        tests_run++;
        if (cnt !== 0) begin
            tests_failed++;
            $display("FAIL b2b_start_ignored: busy/done seen %0d cycles, want 0", cnt);
        end
        mem[0] = 6'd30;
        model_frame(1, apple_pos, apple_valid, parity, el, ea, eb);
        run_frame(1, -1, fd, nd, ol, oa, ob, gl);
        parity = ~parity;
        tests_run++;
        if (fd !== 4 || nd !== 1 || ol !== el || oa !== 1'b1 || ob !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_next: edge %0d cnt %0d leds %h ah %b bh %b, want 4 1 %h 1 0", fd, nd, ol, oa, ob, el);
        end
    endtask

    task automatic test_reset_mid_frame();
        int cnt;
        for (int i = 0; i < 16; i++) mem[i] = 6'($urandom_range(0, 35));
        apple_pos = 6'd0; apple_valid = 1'b1;
        @(negedge clock);
        snake_size = 4'd15; render_start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        render_start = 1'b0;
        repeat (8) @(posedge clock);
        #1 restart_n = 1'b0;
        #1;
        tests_run++;
        if (leds !== 36'd0 || render_busy !== 1'b0 || mem_rd_en !== 1'b0 || render_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_clear: leds=%h busy=%b rd=%b done=%b, want 0", leds, render_busy, mem_rd_en, render_done);
        end
        @(negedge clock);
        restart_n = 1'b1;
        parity = 1'b0;
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clock);
            #1;
            if (render_done) cnt++;
        end
        tests_run++;
        if (cnt !== 0 || leds !== 36'd0) begin
            tests_failed++;
            $display("FAIL midreset_abort: %0d done pulses leds=%h, want 0 and 0", cnt, leds);
        end
        model_frame(15, apple_pos, apple_valid, parity, el, ea, eb);
        run_frame(15, -1, fd, nd, ol, oa, ob, gl);
        parity = ~parity;
        tests_run++;
        if (fd !== 18 || nd !== 1 || ol !== el || oa !== ea || ob !== eb) begin
            tests_failed++;
            $display("FAIL midreset_restart: edge %0d cnt %0d leds %h ah %b bh %b, want 18 1 %h %b %b", fd, nd, ol, oa, ob, el, ea, eb);
        end
    endtask

    task automatic test_blink();
        bit want;
        do_reset();
        mem[0] = 6'd0;
        apple_pos = 6'd5; apple_valid = 1'b1;
        for (int f = 0; f < 3; f++) begin
`ifdef SNAKE_RENDER_APPLE_BLINK_EN
            want = (f != 1);
`else
            want = 1'b1;
`endif
            run_frame(1, -1, fd, nd, ol, oa, ob, gl);
            parity = ~parity;
            tests_run++;
            if (ol[5] !== want || ol[0] !== 1'b1 || fd !== 4) begin
                tests_failed++;
                $display("FAIL blink_frame%0d: bit5=%b bit0=%b edge=%0d, want %b 1 4", f + 1, ol[5], ol[0], fd, want);
            end
        end
    endtask

    task automatic test_random();
        int n, lat;
        for (int t = 0; t < 30; t++) begin
            n = $urandom_range(0, 15);
            for (int i = 0; i < 16; i++) mem[i] = 6'($urandom_range(0, 39));
            if (n > 1 && $urandom_range(0, 2) == 0) mem[$urandom_range(1, n - 1)] = mem[0];
            apple_pos   = 6'($urandom_range(0, 39));
            apple_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) apple_pos = mem[0];
            model_frame(n, apple_pos, apple_valid, parity, el, ea, eb);
            lat = (n == 0) ? 2 : n + 3;
            run_frame(n, -1, fd, nd, ol, oa, ob, gl);
            parity = ~parity;
            tests_run++;
            if (fd !== lat || nd !== 1 || gl) begin
                tests_failed++;
                $display("FAIL rand%0d_timing: n=%0d edge %0d cnt %0d glitch %b, want %0d 1 0", t, n, fd, nd, gl, lat);
            end
            tests_run++;
            if (ol !== el || oa !== ea || ob !== eb) begin
                tests_failed++;
                $display("FAIL rand%0d_frame: n=%0d leds %h ah %b bh %b, want %h %b %b", t, n, ol, oa, ob, el, ea, eb);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty_snake();
        test_head_hits();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_frame();
        test_blink();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/snake_frame_render.md
Name: snake_frame_render

Overview:
- Reader side of the snake body position memory: walks segment entries 0..size-1 and builds the 36-bit frame for the 6x6 LED matrix.
- Overlays the apple and flags head-on-apple and head-on-body for the control unit.
- Sits in the data path between the position memory, written by the movement logic, and the db_leds output.
- Started by the control unit's render command; answers with a one-cycle done pulse.

Parameters:
- GRID_CELLS, 36, number of LED cells; cell index = y*6 + x.
- POS_W, 6, width of a stored cell index.
- ADDR_W, 4, memory address width; max segment count is 2^ADDR_W - 1 = 15.

Ports:
- clock  in  1  system clock.
- restart_n  in  1  asynchronous active-low reset.
- render_start  in  1  pulse; request a new frame.
- snake_size  in  ADDR_W  segment count, 0..15; sampled with render_start.
- apple_pos  in  POS_W  apple cell index.
- apple_valid  in  1  apple present.
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  segment address; entry 0 = head.
- mem_data  in  POS_W  cell index; synchronous memory, valid the cycle after the address is presented.
- render_busy  out  1  frame build in progress.
- render_done  out  1  one-cycle pulse; frame committed.
- leds  out  GRID_CELLS  displayed frame.
- apple_hit  out  1  head cell == apple_pos with apple_valid.
- body_hit  out  1  head cell equals any segment 1..size-1.

Behaviour:
- Reset is asynchronous, active-low on restart_n. While asserted:
  - State IDLE.
  - leds = 0, render_done = 0, render_busy = 0.
  - apple_hit = 0, body_hit = 0.
  - mem_rd_en = 0, mem_addr = 0.
  - Shadow frame cleared.
- Reset mid-frame aborts the frame. No done pulse; leds read 0.
- All outputs are registered.
- FSM states:
  - IDLE: render_start = 1 latches snake_size into N, sets render_busy, goes to CLEAR.
  - CLEAR (1 cycle): shadow = 0, address counter = 0. Goes to READ if N > 0, else to APPLE.
  - READ: mem_rd_en = 1, mem_addr = counter, counter increments each cycle. After address N-1 is issued, goes to DRAIN.
  - DRAIN (1 cycle): receives the last read data, goes to APPLE.
  - APPLE (1 cycle): OR in the apple bit, then commit. On commit, leds <= shadow, apple_hit and body_hit update, render_done = 1 for one cycle, render_busy = 0, back to IDLE.
- Data handling:
  - Every returned mem_data sets shadow[mem_data] on the edge after it is valid.
  - The entry at address 0 is latched as the head.
  - Each later entry is compared with the head; any match sets body_hit.
- Latency, counting the edge that samples render_start as edge 0:
  - render_done rises on edge N+3 for N >= 1.
  - render_done rises on edge 2 for N = 0.
  - leds changes on the same edge as render_done and nowhere else.
- Boundary conditions:
  - mem_data or apple_pos >= 36: no bit set and no hit asserted; the frame continues.
  - Duplicate positions: bit set once, no error.
  - Apple on a body cell: bit set; apple_hit only if the head is on the apple.
  - N = 0: frame holds the apple only; apple_hit = 0, body_hit = 0.
  - apple_valid = 0: no apple bit and apple_hit = 0.
  - apple_pos and apple_valid are sampled in the APPLE state.
  - render_start while busy is ignored. It is not queued.
  - render_start in the same cycle as the done pulse is ignored. It is accepted from the next IDLE cycle onward.
  - mem_addr holds its last value when mem_rd_en = 0.
- apple_hit and body_hit hold between done pulses.

Optional Feature:
- Macro: SNAKE_RENDER_APPLE_BLINK_EN.
- Defined:
  - A 1-bit frame parity register toggles on every render_done; reset value 0.
  - The apple bit is omitted from leds on frames committed while parity = 1.
  - apple_hit is unaffected by parity.
- Undefined: the apple bit is drawn on every frame. No parity register exists.

Test Plan:
- Reset, then N=3, memory {0:14, 1:13, 2:12}, apple_pos=20, apple_valid=1 -> done on edge 6. leds bits 12, 13, 14 and 20 set, all others 0. apple_hit=0, body_hit=0.
- N=0, apple_pos=35, apple_valid=1 -> done on edge 2. leds = 1<<35, apple_hit=0, body_hit=0.
- N=4, memory {7, 8, 14, 7}, apple_pos=7, apple_valid=1 -> body_hit=1, apple_hit=1. leds bits 7, 8, 14 only.
- N=2, memory {40, 3}, apple_valid=0 -> leds = 1<<3, no hits. A second render_start pulsed while busy produces exactly one done pulse.
- N=15, restart_n pulled low on edge 8 -> leds=0, no done pulse. A new render_start after release completes normally on edge 18.
- SNAKE_RENDER_APPLE_BLINK_EN defined: three frames with N=1, memory {0}, apple_pos=5 -> bit 5 set on frames 1 and 3, clear on frame 2.
